// File: rtl/mul_div_iter.sv
// mul_div_iter: iterative RV32M multiply/divide unit for the execute stage.
//   One radix-2 iteration per clock: shift-add for multiply, restoring division
//   for divide. Both work on operand magnitudes. A final FIX cycle applies sign
//   correction and registers the result.
//   Divide-by-zero and signed overflow bypass the iteration and finish the
//   cycle after start is taken.
// Ports:
//   clk, rst         rising-edge clock, async active-high reset
//   start            begin op; only sampled while idle
//   funct3           M-extension op select (MUL..REMU)
//   op_a, op_b       rs1 / rs2 operands, captured at start
//   flush            abort any in-flight op, back to idle
//   busy             op in flight (CALC/FIX/DONE)
//   done             one-cycle completion pulse, result valid alongside
//   result           registered result, held until next completion
module mul_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nx;

  logic [2:0]         f3_q;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   ma, mb;
  logic [2*WIDTH-1:0] prod;   // mul: {acc, multiplier}; div: {remainder, dividend/quotient}
  logic [CW-1:0]      cnt;

  // Decode of the live inputs, used only on the accepting IDLE edge.
  logic             is_div_in, sgn_a_in, sgn_b_in, a_neg_in, b_neg_in;
  logic             div0, ovf, fast, accept;
  logic [WIDTH-1:0] ma_in, mb_in, fast_res;

  always_comb begin
    is_div_in = funct3[2];
    sgn_a_in  = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    sgn_b_in  = sgn_a_in && (funct3 != 3'b010);   // MULHSU: only rs1 signed
    a_neg_in  = sgn_a_in & op_a[WIDTH-1];
    b_neg_in  = sgn_b_in & op_b[WIDTH-1];
    ma_in     = a_neg_in ? -op_a : op_a;
    mb_in     = b_neg_in ? -op_b : op_b;
    div0      = is_div_in && (op_b == '0);
    ovf       = is_div_in && sgn_b_in && (op_a == MIN) && (op_b == '1);
    fast      = div0 | ovf;
    if (div0) fast_res = funct3[1] ? op_a : '1;
    else      fast_res = funct3[1] ? '0   : MIN;
    accept    = (state == IDLE) && start && !flush;
  end

  // One iteration of each algorithm.
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_step, div_step;

  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, ma} : '0);
    mul_step = {mul_sum, prod[WIDTH-1:1]};
    div_sh   = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    div_diff = div_sh - {1'b0, mb};
    if (!div_diff[WIDTH]) div_step = {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
    else                  div_step = {div_sh[WIDTH-1:0],   prod[WIDTH-2:0], 1'b0};
  end

  // Sign correction and result select.
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo, rem, fix_res;

  always_comb begin
    prod_s = (neg_a ^ neg_b) ? -prod : prod;
    quo    = prod[WIDTH-1:0];
    rem    = prod[2*WIDTH-1:WIDTH];
    if (f3_q[2])             fix_res = f3_q[1] ? (neg_a ? -rem : rem)
                                               : ((neg_a ^ neg_b) ? -quo : quo);
    else if (f3_q[1:0] == 0) fix_res = prod_s[WIDTH-1:0];
    else                     fix_res = prod_s[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else begin
      case (state)
        IDLE: if (start) state_nx = fast ? DONE : CALC;
        CALC: if (cnt == CW'(WIDTH-1)) state_nx = FIX;
        FIX:  state_nx = DONE;
        DONE: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      ma     <= '0;
      mb     <= '0;
      prod   <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          f3_q  <= funct3;
          neg_a <= a_neg_in;
          neg_b <= b_neg_in;
          ma    <= ma_in;
          mb    <= mb_in;
          cnt   <= '0;
          prod  <= is_div_in ? {{WIDTH{1'b0}}, ma_in} : {{WIDTH{1'b0}}, mb_in};
          if (fast) result <= fast_res;
        end
        CALC: begin
          cnt  <= cnt + CW'(1);
          prod <= f3_q[2] ? div_step : mul_step;
        end
        FIX: if (!flush) result <= fix_res;
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
